seg7_scan_decoder: RTL and testbench

- Receive direction of the team's binary-to-seven-segment display path.
- Snoops a time-multiplexed, active-low two-digit seven-segment bus (units/tens) and decodes each digit pattern back to BCD.
- Rebuilds the 6-bit binary value (0..63) and commits it only after it has been stable for a number of full scans.
- Used for display loopback self-check and for reading values off panel-style segment buses.

---
 rtl/seg7_scan_decoder.sv | 186 ++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low two-digit seven-segment bus, decodes it back
// to BCD/binary and commits a value once it has been stable for enough scans.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_SCANS = 3,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [1:0] dig_en,
  output logic [5:0] value,
  output logic [3:0] bcd_units,
  output logic [3:0] bcd_tens,
  output logic       valid,
  output logic       update,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    GOT_UNITS,
    EVAL
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  STAB_TGT = 4'(STABLE_SCANS);

  state_t      state, state_nx;
  logic [3:0]  units_q, units_nx;
  logic        units_ok_q, units_ok_nx;
  logic [3:0]  tens_q, tens_nx;
  logic        tens_ok_q, tens_ok_nx;
  logic [15:0] tmo_q, tmo_nx;
  logic [3:0]  stab_q, stab_nx;
  logic [5:0]  cand_q, cand_nx;
  logic [5:0]  value_nx;
  logic [3:0]  bcd_units_nx, bcd_tens_nx;
  logic        valid_nx, update_nx, err_nx;

  logic [6:0]  seg_on;
  logic [3:0]  dig;
  logic        dig_ok;
  logic        cap_units, cap_tens;
  logic [6:0]  sum;
  logic        scan_ok;
  logic [3:0]  stab_inc;
  logic [3:0]  stab_eval;

  assign seg_on    = ~seg_in;
  assign cap_units = (dig_en == 2'b01);
  assign cap_tens  = (dig_en == 2'b10);

  always_comb begin
    dig    = '0;
    dig_ok = 1'b1;
    case (seg_on)
      7'h3F:   dig = 4'd0;
      7'h06:   dig = 4'd1;
      7'h5B:   dig = 4'd2;
      7'h4F:   dig = 4'd3;
      7'h66:   dig = 4'd4;
      7'h6D:   dig = 4'd5;
      7'h7D:   dig = 4'd6;
      7'h07:   dig = 4'd7;
      7'h7F:   dig = 4'd8;
      7'h67:   dig = 4'd9;
      default: dig_ok = 1'b0;
    endcase
  end

  assign sum      = 7'(tens_q) * 7'd10 + 7'(units_q);
  assign scan_ok  = units_ok_q && tens_ok_q && (tens_q <= 4'd6) && (sum <= 7'd63);
  assign stab_inc = (stab_q == 4'hF) ? stab_q : stab_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    units_nx     = units_q;
    units_ok_nx  = units_ok_q;
    tens_nx      = tens_q;
    tens_ok_nx   = tens_ok_q;
    tmo_nx       = tmo_q;
    stab_nx      = stab_q;
    cand_nx      = cand_q;
    value_nx     = value;
    bcd_units_nx = bcd_units;
    bcd_tens_nx  = bcd_tens;
    valid_nx     = valid;
    err_nx       = err;
    update_nx    = 1'b0;
    stab_eval    = '0;

    case (state)
      IDLE: begin
        if (cap_units) begin
          units_nx    = dig;
          units_ok_nx = dig_ok;
          tmo_nx      = '0;
          state_nx    = GOT_UNITS;
        end
      end

      GOT_UNITS: begin
        // A tens capture wins even on the last allowed cycle of the window.
        if (cap_tens) begin
          tens_nx    = dig;
          tens_ok_nx = dig_ok;
          state_nx   = EVAL;
        end else if (cap_units) begin
          units_nx    = dig;
          units_ok_nx = dig_ok;
          tmo_nx      = '0;
        end else if (tmo_q == TMO_LAST) begin
          stab_nx  = '0;
          state_nx = IDLE;
        end else begin
          tmo_nx = tmo_q + 16'd1;
        end
      end

      EVAL: begin
        state_nx = IDLE;
        if (!scan_ok) begin
          err_nx  = 1'b1;
          stab_nx = '0;
        end else begin
          stab_eval = (sum[5:0] == cand_q) ? stab_inc : 4'd1;
          cand_nx   = sum[5:0];
          if (stab_eval == STAB_TGT) begin
            value_nx     = sum[5:0];
            bcd_units_nx = units_q;
            bcd_tens_nx  = tens_q;
            valid_nx     = 1'b1;
            err_nx       = 1'b0;
            update_nx    = 1'b1;
            stab_nx      = '0;
          end else begin
            stab_nx = stab_eval;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      units_q    <= '0;
      units_ok_q <= 1'b0;
      tens_q     <= '0;
      tens_ok_q  <= 1'b0;
      tmo_q      <= '0;
      stab_q     <= '0;
      cand_q     <= '0;
      value      <= '0;
      bcd_units  <= '0;
      bcd_tens   <= '0;
      valid      <= 1'b0;
      update     <= 1'b0;
      err        <= 1'b0;
    end else begin
      units_q    <= units_nx;
      units_ok_q <= units_ok_nx;
      tens_q     <= tens_nx;
      tens_ok_q  <= tens_ok_nx;
      tmo_q      <= tmo_nx;
      stab_q     <= stab_nx;
      cand_q     <= cand_nx;
      value      <= value_nx;
      bcd_units  <= bcd_units_nx;
      bcd_tens   <= bcd_tens_nx;
      valid      <= valid_nx;
      update     <= update_nx;
      err        <= err_nx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench: a scan-level reference model queues expected commits and a
// monitor checks every update pulse and that committed outputs otherwise hold.
module tb_seg7_scan_decoder;

  localparam int STABLE = 3;
  localparam int TMO    = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_in;
  logic [1:0] dig_en;
  logic [5:0] value;
  logic [3:0] bcd_units, bcd_tens;
  logic       valid, update, err;

  seg7_scan_decoder #(.STABLE_SCANS(STABLE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_en(dig_en),
    .value(value), .bcd_units(bcd_units), .bcd_tens(bcd_tens),
    .valid(valid), .update(update), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int value;
    int tens;
    int units;
  } commit_t;

  commit_t    exp_q[$];
  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67};
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, updated once per completed scan
  int m_cand = 0, m_stab = 0, m_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int decode(input logic [6:0] lit);
    for (int i = 0; i < 10; i++) if (pat[i] == lit) return i;
    return -1;
  endfunction

  function automatic logic [6:0] rand_lit();
    logic [6:0] r;
    if ($urandom_range(0, 3) == 0) r = 7'($urandom);
    else r = pat[$urandom_range(0, 9)];
    return r;
  endfunction

  task automatic model_reset();
    m_cand = 0; m_stab = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic model_scan(input logic [6:0] lu, input logic [6:0] lt);
    int u, t, s;
    commit_t c;
    u = decode(lu);
    t = decode(lt);
    s = t * 10 + u;
    if (u < 0 || t < 0 || t > 6 || s > 63) begin
      m_err  = 1;
      m_stab = 0;
    end else begin
      if (s == m_cand) m_stab = (m_stab < 15) ? m_stab + 1 : 15;
      else begin
        m_cand = s;
        m_stab = 1;
      end
      if (m_stab == STABLE) begin
        c.value = s; c.tens = t; c.units = u;
        exp_q.push_back(c);
        m_err  = 0;
        m_stab = 0;
      end
    end
  endtask

  task automatic cyc(input logic [6:0] s, input logic [1:0] d);
    seg_in = s;
    dig_en = d;
    @(posedge clk);
    #1;
  endtask

  // Units, a short gap (may re-capture units), tens, then the evaluation cycle
  task automatic scan(input logic [6:0] lu, input logic [6:0] lt, input int gap, input bit noisy);
    logic [6:0] u;
    int r;
    u = lu;
    cyc(~u, 2'b01);
    for (int i = 0; i < gap; i++) begin
      r = $urandom_range(0, 2);
      if (r == 0) cyc(7'($urandom), 2'b00);
      else if (r == 1) cyc(7'($urandom), 2'b11);
      else begin
        u = rand_lit();
        cyc(~u, 2'b01);
      end
    end
    cyc(~lt, 2'b10);
    model_scan(u, lt);
    cyc(7'($urandom), 2'b00);
    check("err_after_scan", int'(err), m_err);
    if (noisy) begin
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        r = $urandom_range(0, 2);
        cyc(7'($urandom), (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11);
      end
    end
  endtask

  task automatic scan_val(input int v);
    scan(pat[v % 10], pat[v / 10], 0, 1'b0);
  endtask

  // Units, n idle cycles, then tens: accepted only within the timeout window
  task automatic scan_gap(input int v, input int n);
    cyc(~pat[v % 10], 2'b01);
    repeat (n) cyc(7'($urandom), 2'b00);
    cyc(~pat[v / 10], 2'b10);
    if (n + 1 <= TMO) model_scan(pat[v % 10], pat[v / 10]);
    else m_stab = 0;
    cyc(7'($urandom), 2'b00);
    check("err_after_gap_scan", int'(err), m_err);
  endtask

  task automatic check_all_zero(input string name);
    check(name, int'({value, bcd_units, bcd_tens, valid, update, err}), 0);
  endtask

  logic [14:0] prev_hold;
  commit_t     got;

  always @(negedge clk) begin
    if (rst_n) begin
      if (update) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_update: value=%0d, expected no commit at %0t", value, $time);
        end else begin
          got = exp_q.pop_front();
          check("commit_value", int'(value), got.value);
          check("commit_tens", int'(bcd_tens), got.tens);
          check("commit_units", int'(bcd_units), got.units);
          check("commit_valid", int'(valid), 1);
          check("commit_err", int'(err), 0);
        end
      end else begin
        check("hold_outputs", int'({valid, value, bcd_tens, bcd_units}), int'(prev_hold));
      end
    end
    prev_hold = {valid, value, bcd_tens, bcd_units};
  end

  initial begin
    int v, len;
    logic [6:0] lu, lt;
    rst_n  = 1'b0;
    seg_in = '0;
    dig_en = '0;
    prev_hold = '0;
    model_reset();

    // Reset held with random bus activity
    for (int i = 0; i < 5; i++) begin
      cyc(7'($urandom), 2'($urandom));
      check_all_zero("reset_outputs");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(7'($urandom), 2'b00);
      check_all_zero("post_reset_outputs");
    end

    // 42 three times, then 15 twice and 16 three times
    repeat (3) scan_val(42);
    check("value_42", int'(value), 42);
    repeat (2) scan_val(15);
    repeat (3) scan_val(16);
    check("value_16", int'(value), 16);

    // Out-of-range and blank-digit scans, then recovery with 9
    repeat (3) scan_val(42);
    scan(pat[7], pat[6], 0, 1'b0);
    check("err_67", int'(err), 1);
    check("value_held_67", int'(value), 42);
    scan(7'h00, pat[1], 0, 1'b0);
    check("err_blank", int'(err), 1);
    repeat (3) scan_val(9);
    check("value_9", int'(value), 9);
    check("err_cleared", int'(err), 0);

    // Timeout: stability cleared and the late tens ignored
    repeat (3) scan_val(42);
    scan_val(42);
    scan_gap(42, TMO);
    repeat (5) cyc(~pat[5], 2'b11);
    repeat (2) scan_val(42);
    check("no_commit_after_timeout", int'(update), 0);
    scan_gap(42, TMO - 1);
    check("value_42_boundary", int'(value), 42);

    // Asynchronous reset while waiting for tens
    cyc(~pat[2], 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) scan_val(7);
    check("value_7", int'(value), 7);

    // Randomized runs of repeated values with occasional corrupt scans
    for (int r = 0; r < 40; r++) begin
      v   = $urandom_range(0, 63);
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        lu = pat[v % 10];
        lt = pat[v / 10];
        case ($urandom_range(0, 7))
          0: lu = rand_lit();
          1: lt = pat[$urandom_range(7, 9)];
          default: ;
        endcase
        scan(lu, lt, $urandom_range(0, 3), 1'b1);
      end
    end

    repeat (5) cyc(7'($urandom), 2'b00);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
